fifo_wr_strobes: RTL and testbench

- Byte-lane write-strobe decoder for the SDMAC 32-bit FIFO.
- Converts the latched transfer size (long-word halves or single byte) and the byte offset into four per-lane write strobes.
- Lanes: UU = bits 31:24, UM = 23:16, LM = 15:8, LL = 7:0. Big-endian lane ordering.
- Sits between the bus-size/offset latch logic and the FIFO byte-lane write enables.

---
 rtl/fifo_wr_strobes_pkg.sv | 33 +++
 rtl/fifo_ws_decode.sv | 39 +++
 rtl/fifo_wr_strobes.sv | 84 ++++++++
 tb/tb_fifo_wr_strobes.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_strobes_pkg.sv
// Shared lane/offset constants and the byte-offset-to-lane helper for the SDMAC FIFO write-strobe decoder.
// Lanes are big-endian: offset 0 selects bits 31:24 (UU), offset 3 selects bits 7:0 (LL).
package fifo_wr_strobes_pkg;

  localparam int NUM_LANES = 4;

  localparam int LANE_UU = 3;
  localparam int LANE_UM = 2;
  localparam int LANE_LM = 1;
  localparam int LANE_LL = 0;

  localparam logic [1:0] OFS_UU = 2'b00;
  localparam logic [1:0] OFS_UM = 2'b01;
  localparam logic [1:0] OFS_LM = 2'b10;
  localparam logic [1:0] OFS_LL = 2'b11;

  typedef logic [NUM_LANES-1:0] lane_mask_t;

  // One-hot lane selected by a byte offset {BO1,BO0}.
  function automatic lane_mask_t byte_lane_mask(input logic [1:0] ofs);
    lane_mask_t m;
    m = '0;
    case (ofs)
      OFS_UU:  m[LANE_UU] = 1'b1;
      OFS_UM:  m[LANE_UM] = 1'b1;
      OFS_LM:  m[LANE_LM] = 1'b1;
      OFS_LL:  m[LANE_LL] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fifo_ws_decode.sv
// Pure combinational write-strobe equations: word terms OR'd with the byte-offset term.
// CONFLICT output exists only when FIFO_WS_CONFLICT_EN is defined.
module fifo_ws_decode
  import fifo_wr_strobes_pkg::*;
(
  input  logic [1:0] i_bo,
  input  logic       i_lhword,
  input  logic       i_llword,
  input  logic       i_lbyte_n,
  output lane_mask_t o_ws
`ifdef FIFO_WS_CONFLICT_EN
  ,
  output logic       o_conflict
`endif
);

  logic       w_byte;
  lane_mask_t w_byte_mask;
  lane_mask_t w_word_mask;

  assign w_byte      = ~i_lbyte_n;
  assign w_byte_mask = w_byte ? byte_lane_mask(i_bo) : '0;

  always_comb begin
    w_word_mask          = '0;
    w_word_mask[LANE_UU] = i_lhword;
    w_word_mask[LANE_UM] = i_lhword;
    w_word_mask[LANE_LM] = i_llword;
    w_word_mask[LANE_LL] = i_llword;
  end

  // Word and byte requests may coexist; the union of lanes is written.
  assign o_ws = w_word_mask | w_byte_mask;

`ifdef FIFO_WS_CONFLICT_EN
  assign o_conflict = w_byte & (i_lhword | i_llword);
`endif

endmodule

// File: rtl/fifo_wr_strobes.sv
// Byte-lane write-strobe decoder for the SDMAC 32-bit FIFO, optionally registered (OUT_REG).
// Optional CONFLICT output guarded by macro FIFO_WS_CONFLICT_EN.
module fifo_wr_strobes
  import fifo_wr_strobes_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic CLK,
  input  logic RST_,
  input  logic BO0,
  input  logic BO1,
  input  logic LHWORD,
  input  logic LLWORD,
  input  logic LBYTE_,
  output logic UUWS,
  output logic UMWS,
  output logic LMWS,
  output logic LLWS
`ifdef FIFO_WS_CONFLICT_EN
  ,
  output logic CONFLICT
`endif
);

  lane_mask_t w_ws;
  lane_mask_t w_ws_out;
  logic       w_conflict;
  logic       w_conflict_out;

  fifo_ws_decode u_decode (
    .i_bo      ({BO1, BO0}),
    .i_lhword  (LHWORD),
    .i_llword  (LLWORD),
    .i_lbyte_n (LBYTE_),
    .o_ws      (w_ws)
`ifdef FIFO_WS_CONFLICT_EN
    ,
    .o_conflict(w_conflict)
`endif
  );

`ifndef FIFO_WS_CONFLICT_EN
  assign w_conflict = 1'b0;
`endif

  generate
    if (OUT_REG != 0) begin : g_reg
      lane_mask_t r_ws;
      logic       r_conflict;

      // No clock enable: reload every cycle, reset dominates the inputs.
      always_ff @(posedge CLK) begin
        if (!RST_) begin
          r_ws       <= '0;
          r_conflict <= 1'b0;
        end else begin
          r_ws       <= w_ws;
          r_conflict <= w_conflict;
        end
      end

      assign w_ws_out       = r_ws;
      assign w_conflict_out = r_conflict;
    end else begin : g_comb
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = CLK ^ RST_;
      assign w_ws_out         = w_ws;
      assign w_conflict_out   = w_conflict;
    end
  endgenerate

  assign UUWS = w_ws_out[LANE_UU];
  assign UMWS = w_ws_out[LANE_UM];
  assign LMWS = w_ws_out[LANE_LM];
  assign LLWS = w_ws_out[LANE_LL];

`ifdef FIFO_WS_CONFLICT_EN
  assign CONFLICT = w_conflict_out;
`else
  logic w_unused_conflict;
  assign w_unused_conflict = w_conflict_out;
`endif

endmodule

// File: tb/tb_fifo_wr_strobes.sv
// Bench for fifo_wr_strobes: registered and combinational instances against a lane-set model.
// Honours FIFO_WS_CONFLICT_EN when defined.
module tb_fifo_wr_strobes;

  logic clk;
  logic rst_n;
  logic bo0, bo1, lhword, llword, lbyte_n;

  logic r_uu, r_um, r_lm, r_ll, r_cf;
  logic c_uu, c_um, c_lm, c_ll, c_cf;

  int n_cmp;
  int n_err;
  bit chk_en;

  logic [4:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  fifo_wr_strobes #(.OUT_REG(1)) u_reg (
    .CLK(clk), .RST_(rst_n), .BO0(bo0), .BO1(bo1),
    .LHWORD(lhword), .LLWORD(llword), .LBYTE_(lbyte_n),
    .UUWS(r_uu), .UMWS(r_um), .LMWS(r_lm), .LLWS(r_ll)
`ifdef FIFO_WS_CONFLICT_EN
    , .CONFLICT(r_cf)
`endif
  );

  fifo_wr_strobes #(.OUT_REG(0)) u_comb (
    .CLK(clk), .RST_(rst_n), .BO0(bo0), .BO1(bo1),
    .LHWORD(lhword), .LLWORD(llword), .LBYTE_(lbyte_n),
    .UUWS(c_uu), .UMWS(c_um), .LMWS(c_lm), .LLWS(c_ll)
`ifdef FIFO_WS_CONFLICT_EN
    , .CONFLICT(c_cf)
`endif
  );

`ifndef FIFO_WS_CONFLICT_EN
  assign r_cf = 1'b0;
  assign c_cf = 1'b0;
`endif

  // ---------------- model ----------------
  // Returns {conflict, UU, UM, LM, LL} from the lane-set description.
  function automatic logic [4:0] model(input logic b1, input logic b0,
                                       input logic lh, input logic ll, input logic lb_n);
    logic [3:0] lanes;
    logic       cf;
    int         ofs;
    lanes = 4'b0000;
    cf    = 1'b0;
    if (lh) lanes = lanes | 4'b1100;
    if (ll) lanes = lanes | 4'b0011;
    if (!lb_n) begin
      ofs = {30'd0, b1, b0};
      lanes[3 - ofs] = 1'b1;
`ifdef FIFO_WS_CONFLICT_EN
      cf = lh | ll;
`endif
    end
    return {cf, lanes};
  endfunction

  function automatic logic [4:0] act_reg();
    return {r_cf, r_uu, r_um, r_lm, r_ll};
  endfunction

  function automatic logic [4:0] act_comb();
    return {c_cf, c_uu, c_um, c_lm, c_ll};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (!rst_n) exp_q.push_back(5'b00000);
    else        exp_q.push_back(model(bo1, bo0, lhword, llword, lbyte_n));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) check("reg_stream", act_reg(), exp_q.pop_front());
      check("comb_stream", act_comb(), model(bo1, bo0, lhword, llword, lbyte_n));
    end else begin
      exp_q.delete();
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic b1, input logic b0,
                       input logic lh, input logic ll, input logic lb_n);
    @(posedge clk);
    #1;
    rst_n = rst; bo1 = b1; bo0 = b0; lhword = lh; llword = ll; lbyte_n = lb_n;
  endtask

  // Wait past the edge that samples the last drive, then check strobes only.
  task automatic lit(input string name, input logic [3:0] exp_reg, input logic [3:0] exp_comb);
    @(posedge clk);
    #2;
    check({name, "_reg"},  {1'b0, act_reg()  & 5'b01111}, {1'b0, exp_reg});
    check({name, "_comb"}, {1'b0, act_comb() & 5'b01111}, {1'b0, exp_comb});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0; chk_en = 1'b0;
    rst_n = 1'b0; bo0 = 1'b0; bo1 = 1'b0; lhword = 1'b1; llword = 1'b1; lbyte_n = 1'b1;

    // Reset held two edges with both word writes requested.
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #2;
    check("reset_reg", act_reg(), 5'b00000);
    check("reset_comb", act_comb(), 5'b01111);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    lit("post_reset", 4'b1111, 4'b1111);

    // Byte sweep.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); lit("byte_ofs0", 4'b1000, 4'b1000);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); lit("byte_ofs1", 4'b0100, 4'b0100);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); lit("byte_ofs2", 4'b0010, 4'b0010);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); lit("byte_ofs3", 4'b0001, 4'b0001);

    // Word modes and idle across all offsets.
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, b[1], b[0], 1'b1, 1'b0, 1'b1); lit("hi_word", 4'b1100, 4'b1100);
      drive(1'b1, b[1], b[0], 1'b0, 1'b1, 1'b1); lit("lo_word", 4'b0011, 4'b0011);
      drive(1'b1, b[1], b[0], 1'b0, 0, 1'b1);    lit("idle", 4'b0000, 4'b0000);
    end

    // Overlap of byte and low word.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    lit("overlap", 4'b1011, 4'b1011);
`ifdef FIFO_WS_CONFLICT_EN
    check("conflict_set", {4'b0000, r_cf}, 5'b00001);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    lit("overlap_word", 4'b0011, 4'b0011);
    check("conflict_clr", {4'b0000, r_cf}, 5'b00000);
`endif

    // Reset mid-operation clears on the next edge.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    lit("mid_reset", 4'b0000, 4'b1111);

    // Exhaustive sweep of all 32 input combinations.
    for (int v = 0; v < 32; v++) begin
      drive(1'b1, v[4], v[3], v[2], v[1], v[0]);
    end

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
